// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: two-stage carry-lookahead adder/subtractor with valid/ready flow control.
// S1 holds bit and group generate/propagate, S2 holds the resolved sum and flags.
module pipelined_cla_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NG = WIDTH / GROUP;

  // Flattened sum-of-products carry into bit hi from generate/propagate bits lo..hi-1.
  function automatic logic lookahead(input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] p,
                                     input logic ci, input int lo, input int hi);
    logic c, t;
    c = 1'b0;
    t = 1'b1;
    for (int m = WIDTH - 1; m >= 0; m--)
      if (m >= lo && m < hi) begin
        c = c | (t & g[m]);
        t = t & p[m];
      end
    return c | (t & ci);
  endfunction

  logic [WIDTH-1:0] w_bx, w_p, w_g, w_ggx, w_ppx, w_sum;
  logic [NG-1:0]    w_gg, w_pp;
  logic [NG:0]      w_gc;
  logic [WIDTH:0]   w_c;
  logic             w_s1_load, w_s2_load;
  logic [WIDTH-1:0] r_p, r_g, r_sum;
  logic [NG-1:0]    r_gg, r_pp;
  logic             r_c0, r_v1, r_v2, r_cout, r_ovf, r_zero;

  assign w_bx = b ^ {WIDTH{sub}};
  assign w_p  = a ^ w_bx;
  assign w_g  = a & w_bx;

  always_comb begin
    w_gg = '0;
    w_pp = '0;
    for (int k = 0; k < NG; k++) begin
      w_gg[k] = lookahead(w_g, w_p, 1'b0, k * GROUP, k * GROUP + GROUP);
      w_pp[k] = &w_p[k*GROUP +: GROUP];
    end
  end

  always_comb begin
    w_ggx = '0;
    w_ppx = '0;
    w_ggx[NG-1:0] = r_gg;
    w_ppx[NG-1:0] = r_pp;
    w_gc = '0;
    for (int k = 0; k <= NG; k++)
      w_gc[k] = lookahead(w_ggx, w_ppx, r_c0, 0, k);
  end

  always_comb begin
    w_c = '0;
    for (int i = 0; i < WIDTH; i++)
      w_c[i] = lookahead(r_g, r_p, w_gc[i/GROUP], (i / GROUP) * GROUP, i);
    w_c[WIDTH] = w_gc[NG];
  end

  assign w_sum     = r_p ^ w_c[WIDTH-1:0];
  assign w_s2_load = !r_v2 || out_ready;
  assign w_s1_load = !r_v1 || w_s2_load;
  assign in_ready  = !rst && w_s1_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_p  <= '0;
      r_g  <= '0;
      r_gg <= '0;
      r_pp <= '0;
      r_c0 <= 1'b0;
    end else if (w_s1_load) begin
      r_v1 <= in_valid;
      r_p  <= w_p;
      r_g  <= w_g;
      r_gg <= w_gg;
      r_pp <= w_pp;
      r_c0 <= sub | cin;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2   <= 1'b0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_s2_load) begin
      r_v2   <= r_v1;
      r_sum  <= w_sum;
      r_cout <= w_c[WIDTH];
      r_ovf  <= w_c[WIDTH] ^ w_c[WIDTH-1];
      r_zero <= ~|w_sum;
    end
  end

  assign out_valid = r_v2;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: randomized and directed checks of the pipelined adder against an arithmetic model.
module tb_pipelined_cla_adder;
  typedef struct packed {logic [31:0] s; logic c; logic o; logic z;} res_t;

  logic        clk, rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
  logic [31:0] a, b, sum;
  int          ntest, nfail, cyc, lat;
  logic        acc, con, has_exp, s_ir, s_ov;
  res_t        got, ex;
  res_t        q[$];
  int          qc[$];

  logic [31:0] da[6]   = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'd5, 32'd7, 32'd0, 32'h80000000};
  logic [31:0] db[6]   = '{32'd1, 32'd1, 32'd7, 32'd5, 32'd0, 32'd1};
  logic        dci[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic        dsub[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [34:0] dexp[6] = '{{32'h00000000, 1'b1, 1'b0, 1'b1}, {32'h80000000, 1'b0, 1'b1, 1'b0},
                           {32'hFFFFFFFE, 1'b0, 1'b0, 1'b0}, {32'h00000002, 1'b1, 1'b0, 1'b0},
                           {32'h00000000, 1'b1, 1'b0, 1'b1}, {32'h7FFFFFFF, 1'b1, 1'b1, 1'b0}};

  pipelined_cla_adder #(.WIDTH(32), .GROUP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf), .zero(zero));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic sb);
    res_t r;
    logic [31:0] yy;
    logic [32:0] t;
    yy = sb ? ~y : y;
    t = {1'b0, x} + {1'b0, yy} + {32'b0, sb | ci};
    r.s = t[31:0];
    r.c = t[32];
    r.o = (x[31] == yy[31]) && (t[31] != x[31]);
    r.z = (t[31:0] == 32'd0);
    return r;
  endfunction

  task automatic rnd_op();
    a = $urandom;
    b = $urandom;
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 7) == 0) b = a;
    if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFFF;
  endtask

  // Samples handshakes just after the negedge, tracks the expected queue, then advances one cycle.
  task automatic cycle();
    #1;
    acc = in_valid && in_ready;
    con = out_valid && out_ready;
    s_ir = in_ready;
    s_ov = out_valid;
    got = {sum, cout, ovf, zero};
    has_exp = 1'b0;
    lat = -1;
    if (con && q.size() > 0) begin
      ex = q.pop_front();
      lat = cyc - qc.pop_front();
      has_exp = 1'b1;
    end
    if (acc) begin
      q.push_back(model(a, b, cin, sub));
      qc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    ntest++;
    if ({out_valid, in_ready, sum, cout, ovf, zero} !== 37'd0) begin
      nfail++;
      $display("FAIL reset_state: got ov=%b ir=%b sum=%h c=%b o=%b z=%b want all zero",
               out_valid, in_ready, sum, cout, ovf, zero);
    end
    rst = 1'b0;
    #1;
    ntest++;
    if (in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_directed();
    int sent = 0, rcv = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && rcv < 6; k++) begin
      in_valid = (sent < 6);
      if (sent < 6) begin
        a = da[sent]; b = db[sent]; cin = dci[sent]; sub = dsub[sent];
      end
      cycle();
      if (acc) sent++;
      if (con) begin
        ntest++;
        if (got !== dexp[rcv] || lat != 2) begin
          nfail++;
          $display("FAIL directed[%0d]: got %h lat %0d want %h lat 2", rcv, got, lat, dexp[rcv]);
        end
        rcv++;
      end
    end
    in_valid = 1'b0;
    ntest++;
    if (rcv != 6) begin
      nfail++;
      $display("FAIL directed_count: got %0d want 6", rcv);
    end
  endtask

  task automatic test_backpressure();
    int sent = 0, rcv = 0;
    res_t held;
    logic have_held = 1'b0;
    rnd_op();
    for (int k = 0; k < 40 && rcv < 4; k++) begin
      out_ready = (k >= 5);
      in_valid = (sent < 4);
      cycle();
      if (acc) begin
        sent++;
        rnd_op();
      end
      if (!out_ready && s_ov) begin
        ntest++;
        if (have_held && got !== held) begin
          nfail++;
          $display("FAIL stall_hold: got %h want %h", got, held);
        end
        held = got;
        have_held = 1'b1;
      end
      if (!out_ready && k >= 2) begin
        ntest++;
        if (s_ir !== 1'b0 || sent != 2) begin
          nfail++;
          $display("FAIL stall_in_ready: got ir=%b accepted=%0d want ir=0 accepted=2", s_ir, sent);
        end
      end
      if (con) begin
        ntest++;
        if (!has_exp || got !== ex) begin
          nfail++;
          $display("FAIL backpressure_beat[%0d]: got %h want %h", rcv, got, ex);
        end
        rcv++;
      end
    end
    in_valid = 1'b0;
    ntest++;
    if (rcv != 4 || q.size() != 0) begin
      nfail++;
      $display("FAIL backpressure_count: got %0d left %0d want 4 left 0", rcv, q.size());
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0, rcv = 0;
    out_ready = 1'b1;
    rnd_op();
    for (int k = 0; k < 120 && rcv < 100; k++) begin
      in_valid = (sent < 100);
      cycle();
      if (acc) begin
        sent++;
        rnd_op();
      end
      if (k < 100) begin
        ntest++;
        if (s_ir !== 1'b1) begin
          nfail++;
          $display("FAIL b2b_in_ready[%0d]: got %b want 1", k, s_ir);
        end
      end
      if (con) begin
        ntest++;
        if (!has_exp || got !== ex || lat != 2) begin
          nfail++;
          $display("FAIL b2b_beat[%0d]: got %h lat %0d want %h lat 2", rcv, got, lat, ex);
        end
        rcv++;
      end
    end
    in_valid = 1'b0;
    ntest++;
    if (rcv != 100) begin
      nfail++;
      $display("FAIL b2b_count: got %0d want 100", rcv);
    end
  endtask

  task automatic test_random_stall();
    int sent = 0, rcv = 0;
    rnd_op();
    for (int k = 0; k < 600 && rcv < 50; k++) begin
      in_valid = (sent < 50) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
      if (acc) begin
        sent++;
        rnd_op();
      end
      if (con) begin
        ntest++;
        if (!has_exp || got !== ex) begin
          nfail++;
          $display("FAIL random_beat[%0d]: got %h want %h", rcv, got, ex);
        end
        rcv++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    ntest++;
    if (rcv != 50 || q.size() != 0) begin
      nfail++;
      $display("FAIL random_count: got %0d left %0d want 50 left 0", rcv, q.size());
    end
  endtask

  task automatic test_reset_mid();
    int rcv = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    rnd_op();
    cycle();
    rnd_op();
    cycle();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    ntest++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || sum !== 32'd0) begin
      nfail++;
      $display("FAIL async_reset: got ov=%b ir=%b sum=%h want 0 0 0", out_valid, in_ready, sum);
    end
    q.delete();
    qc.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      ntest++;
      if (s_ov !== 1'b0 || (k == 0 && s_ir !== 1'b1)) begin
        nfail++;
        $display("FAIL post_reset_idle[%0d]: got ov=%b ir=%b want ov=0 ir=1", k, s_ov, s_ir);
      end
    end
    in_valid = 1'b1;
    rnd_op();
    for (int k = 0; k < 8 && rcv < 1; k++) begin
      cycle();
      in_valid = 1'b0;
      if (con) begin
        ntest++;
        if (!has_exp || got !== ex || lat != 2) begin
          nfail++;
          $display("FAIL post_reset_beat: got %h lat %0d want %h lat 2", got, lat, ex);
        end
        rcv++;
      end
    end
    ntest++;
    if (rcv != 1) begin
      nfail++;
      $display("FAIL post_reset_count: got %0d want 1", rcv);
    end
  endtask

  initial begin
    ntest = 0; nfail = 0; cyc = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
